lsq_mem_arbiter: RTL and testbench

Shares the single data-memory port between the load buffer (in-order load reads) and the store queue (retiring store writes). It holds at most one outstanding load and tracks that load's memory tag until the data returns. It enforces store-before-load ordering on same-word conflicts and prevents store starvation. The block sits between the LSQ and the memory-bus interface in the no-cache pipeline.

---
 rtl/lsq_mem_arbiter_pkg.sv | 39 +++
 rtl/lsq_mem_arbiter_starve_counter.sv | 27 ++
 rtl/lsq_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_lsq_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lsq_mem_arbiter_pkg.sv
// Shared types for the LSQ memory-port arbiter: bus commands, sizes, FSM states, request payload.
package lsq_mem_arbiter_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned CMD_W  = 2;

  typedef enum logic [CMD_W-1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_e;

  typedef enum logic [SIZE_W-1:0] {
    MEM_BYTE   = 3'h0,
    MEM_HALF   = 3'h1,
    MEM_WORD   = 3'h2,
    MEM_DOUBLE = 3'h3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'h0,
    WAIT = 2'h1,
    DROP = 2'h2
  } lsq_arb_state_e;

  typedef struct packed {
    bus_command_e      cmd;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [SIZE_W-1:0] size;
  } mem_req_t;

  // Two byte addresses fall in the same 32-bit word.
  function automatic logic same_word(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return a[XLEN-1:2] == b[XLEN-1:2];
  endfunction

endpackage

// File: rtl/lsq_mem_arbiter_starve_counter.sv
// Saturating counter of cycles a store has waited without being accepted.
module starve_counter #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  assign sat = (r_cnt == CW'(LIMIT));

  // Count up while waiting, hold at the limit, clear when the store leaves or is accepted.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (inc && !sat) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lsq_mem_arbiter.sv
// Arbitrates the single data-memory port between in-order loads and retiring stores,
// tracking the one outstanding load tag and squashing it on flush.
module lsq_mem_arbiter
  import lsq_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TAG_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [2:0]        ld_size,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  input  logic              st_req,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_size,
  output logic              st_ack,
  output logic [1:0]        proc2mem_command,
  output logic [31:0]       proc2mem_addr,
  output logic [31:0]       proc2mem_data,
  output logic [2:0]        proc2mem_size,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  input  logic [31:0]       mem2proc_data
);

  lsq_arb_state_e   r_state;
  lsq_arb_state_e   w_state_nxt;
  logic [TAG_W-1:0] r_ld_tag;
  logic [TAG_W-1:0] w_ld_tag_nxt;

  logic     w_starve_sat;
  logic     w_ld_elig;
  logic     w_st_elig;
  logic     w_issue_ld;
  logic     w_issue_st;
  logic     w_accepted;
  logic     w_tag_match;
  mem_req_t w_req;

  assign w_accepted  = (mem2proc_response != '0);
  assign w_tag_match = (mem2proc_tag != '0) && (mem2proc_tag == r_ld_tag);

  // Pick at most one requester: starving store, same-word store, load, then store.
  always_comb begin
    w_ld_elig  = 1'b0;
    w_st_elig  = 1'b0;
    w_issue_ld = 1'b0;
    w_issue_st = 1'b0;
    w_ld_elig  = !reset && (r_state == IDLE) && ld_req && !flush;
    w_st_elig  = !reset && st_req;
    if (w_st_elig && (w_starve_sat || !w_ld_elig || same_word(st_addr, ld_addr))) begin
      w_issue_st = 1'b1;
    end else if (w_ld_elig) begin
      w_issue_ld = 1'b1;
    end
  end

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clock (clock),
    .reset (reset),
    .inc   (w_st_elig && !st_ack),
    .clr   (!st_req || st_ack),
    .sat   (w_starve_sat)
  );

  // FSM state and outstanding-load tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ld_tag <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ld_tag <= w_ld_tag_nxt;
    end
  end

  // Next state: accept a load, retire or squash it on tag return.
  always_comb begin
    w_state_nxt  = r_state;
    w_ld_tag_nxt = r_ld_tag;
    case (r_state)
      IDLE: begin
        if (w_issue_ld && w_accepted) begin
          w_state_nxt  = WAIT;
          w_ld_tag_nxt = mem2proc_response;
        end
      end
      WAIT: begin
        if (w_tag_match) begin
          w_state_nxt  = IDLE;
          w_ld_tag_nxt = '0;
        end else if (flush) begin
          w_state_nxt  = DROP;
        end
      end
      DROP: begin
        if (w_tag_match) begin
          w_state_nxt  = IDLE;
          w_ld_tag_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_ld_tag_nxt = '0;
      end
    endcase
  end

  // Outputs: bus request, store ack, load data return (suppressed on flush).
  always_comb begin
    w_req    = '0;
    st_ack   = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    if (w_issue_st) begin
      w_req.cmd  = BUS_STORE;
      w_req.addr = st_addr;
      w_req.data = st_data;
      w_req.size = st_size;
      st_ack     = w_accepted;
    end else if (w_issue_ld) begin
      w_req.cmd  = BUS_LOAD;
      w_req.addr = ld_addr;
      w_req.size = ld_size;
    end
    if (!reset && (r_state == WAIT) && w_tag_match && !flush) begin
      ld_valid = 1'b1;
      ld_data  = mem2proc_data;
    end
  end

  assign proc2mem_command = w_req.cmd;
  assign proc2mem_addr    = w_req.addr;
  assign proc2mem_data    = w_req.data;
  assign proc2mem_size    = w_req.size;

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Scoreboard bench for lsq_mem_arbiter: directed scenarios then random traffic,
// expected responses come from a transaction-level model of the port rules.
module tb_lsq_mem_arbiter;
  import lsq_mem_arbiter_pkg::*;

  localparam int LIMIT = 8;
  localparam int TW    = 4;

  logic          clock = 1'b0;
  always #5 clock = ~clock;

  logic          s_reset, s_flush, s_ld_req, s_st_req;
  logic [31:0]   s_ld_addr, s_st_addr, s_st_data, s_mdata;
  logic [2:0]    s_ld_size, s_st_size;
  logic [TW-1:0] s_resp, s_tag;

  logic          ld_valid, st_ack;
  logic [31:0]   ld_data, p_addr, p_data;
  logic [1:0]    p_cmd;
  logic [2:0]    p_size;

  lsq_mem_arbiter #(.STARVE_LIMIT(LIMIT), .TAG_W(TW)) dut (
    .clock(clock), .reset(s_reset), .flush(s_flush),
    .ld_req(s_ld_req), .ld_addr(s_ld_addr), .ld_size(s_ld_size),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .st_req(s_st_req), .st_addr(s_st_addr), .st_data(s_st_data), .st_size(s_st_size),
    .st_ack(st_ack),
    .proc2mem_command(p_cmd), .proc2mem_addr(p_addr), .proc2mem_data(p_data),
    .proc2mem_size(p_size),
    .mem2proc_response(s_resp), .mem2proc_tag(s_tag), .mem2proc_data(s_mdata)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic        st_ack;
    logic        ld_valid;
    logic [31:0] ld_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Model: at most one load in flight (possibly squashed), plus store wait count.
  bit   m_pend   = 0;
  bit   m_squash = 0;
  int   m_tag    = 0;
  int   m_wait   = 0;
  int   m_due    = 0;

  task automatic set_idle();
    s_reset = 0; s_flush = 0; s_ld_req = 0; s_st_req = 0;
    s_ld_addr = 0; s_st_addr = 0; s_st_data = 0; s_mdata = 0;
    s_ld_size = 0; s_st_size = 0; s_resp = 0; s_tag = 0;
  endtask

  // Evaluate the current inputs against the model, queue the expectation, advance a cycle.
  task automatic step();
    exp_t e;
    bit load_ok, take_st, take_ld, acc, hit;
    e = '{cmd: BUS_NONE, addr: 0, data: 0, size: 0, st_ack: 0, ld_valid: 0, ld_data: 0};
    if (s_reset) begin
      m_pend = 0; m_squash = 0; m_tag = 0; m_wait = 0;
    end else begin
      load_ok = !m_pend && s_ld_req && !s_flush;
      take_st = s_st_req && (m_wait >= LIMIT || !load_ok ||
                             (s_st_addr[31:2] == s_ld_addr[31:2]));
      take_ld = load_ok && !take_st;
      acc     = (s_resp != 0);
      if (take_st) begin
        e.cmd = BUS_STORE; e.addr = s_st_addr; e.data = s_st_data; e.size = s_st_size;
        e.st_ack = acc;
      end else if (take_ld) begin
        e.cmd = BUS_LOAD; e.addr = s_ld_addr; e.size = s_ld_size;
      end
      hit = m_pend && (s_tag != 0) && (int'(s_tag) == m_tag);
      if (hit) begin
        if (!m_squash && !s_flush) begin
          e.ld_valid = 1; e.ld_data = s_mdata;
        end
        m_pend = 0; m_squash = 0; m_tag = 0;
      end else if (m_pend && s_flush) begin
        m_squash = 1;
      end
      if (take_ld && acc) begin
        m_pend = 1; m_squash = 0; m_tag = int'(s_resp);
        m_due  = cyc + int'($urandom_range(4, 1));
      end
      if (!s_st_req || e.st_ack) m_wait = 0;
      else if (m_wait < LIMIT)   m_wait = m_wait + 1;
    end
    exp_q.push_back(e);
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic rand_stim();
    set_idle();
    if ($urandom_range(99) < 1) begin
      s_reset = 1;
      return;
    end
    s_flush   = ($urandom_range(99) < 5);
    s_ld_req  = m_pend ? 1'b1 : ($urandom_range(99) < 60);
    s_ld_addr = $urandom & 32'h0000_0FFF;
    s_ld_size = 3'($urandom_range(3));
    s_st_req  = ($urandom_range(99) < 50);
    s_st_addr = ($urandom_range(99) < 30) ? ((s_ld_addr & ~32'h3) | 32'($urandom_range(3)))
                                          : ($urandom & 32'h0000_0FFF);
    s_st_data = $urandom;
    s_st_size = 3'($urandom_range(3));
    s_resp    = ($urandom_range(99) < 70) ? TW'($urandom_range(15, 1)) : '0;
    s_mdata   = $urandom;
    if (m_pend && cyc >= m_due && $urandom_range(99) < 80) begin
      s_tag = TW'(m_tag);
    end else begin
      s_tag = TW'($urandom_range(15));
      if (m_pend && int'(s_tag) == m_tag) s_tag = '0;
    end
  endtask

  // Monitor: compare every DUT cycle against the next queued expectation.
  always @(negedge clock) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (p_cmd !== e.cmd || p_addr !== e.addr || p_data !== e.data || p_size !== e.size ||
          st_ack !== e.st_ack || ld_valid !== e.ld_valid || ld_data !== e.ld_data) begin
        n_err++;
        $display("FAIL port_cycle t=%0t got cmd=%0d addr=%h data=%h size=%0d ack=%b vld=%b ldd=%h want cmd=%0d addr=%h data=%h size=%0d ack=%b vld=%b ldd=%h",
                 $time, p_cmd, p_addr, p_data, p_size, st_ack, ld_valid, ld_data,
                 e.cmd, e.addr, e.data, e.size, e.st_ack, e.ld_valid, e.ld_data);
      end
    end
  end

  initial begin
    set_idle();
    @(posedge clock);
    #1;
    s_reset = 1; step(); step();
    set_idle(); step();

    // Single load: accepted with tag 3, returns two cycles later, request held meanwhile.
    s_ld_req = 1; s_ld_addr = 32'h100; s_ld_size = 3'd2; s_resp = 3; step();
    s_resp = 0; step();
    s_tag = 3; s_mdata = 32'hDEADBEEF; step();
    set_idle(); step();

    // Rejected twice, accepted with tag 5, then returns.
    s_ld_req = 1; s_ld_addr = 32'h140; s_ld_size = 3'd2;
    s_resp = 0; step(); step();
    s_resp = 5; step();
    s_resp = 0; step();
    s_tag = 5; s_mdata = 32'h1234_5678; step();
    set_idle(); step();

    // Same-word store goes first, load next cycle.
    s_st_req = 1; s_st_addr = 32'h200; s_st_data = 32'hCAFE_F00D; s_st_size = 3'd2;
    s_ld_req = 1; s_ld_addr = 32'h202; s_ld_size = 3'd1; s_resp = 1; step();
    s_st_req = 0; s_resp = 2; step();
    s_resp = 0; s_tag = 2; s_mdata = 32'hA5A5_0001; step();
    set_idle(); step();

    // Starvation: loads keep winning but are rejected; store must be forced through.
    s_st_req = 1; s_st_addr = 32'h400; s_st_data = 32'h0BAD_F00D;
    s_ld_req = 1; s_ld_addr = 32'h800; s_resp = 0;
    repeat (10) step();
    s_resp = 7; step();
    set_idle(); step();

    // Flush while waiting: response dropped, later load still served.
    s_ld_req = 1; s_ld_addr = 32'h300; s_resp = 2; step();
    s_resp = 0; s_flush = 1; step();
    set_idle(); s_ld_req = 1; s_ld_addr = 32'h304; s_resp = 9; step();
    set_idle(); s_tag = 2; s_mdata = 32'hFFFF_0000; step();
    s_tag = 0; s_ld_req = 1; s_ld_addr = 32'h304; s_resp = 4; step();
    s_resp = 0; s_tag = 4; s_mdata = 32'h0000_4444; step();
    set_idle(); step();

    // Reset while waiting: the stale tag must not produce data.
    s_ld_req = 1; s_ld_addr = 32'h500; s_resp = 6; step();
    set_idle(); s_reset = 1; step();
    set_idle(); s_tag = 6; s_mdata = 32'h6666_6666; step();
    set_idle(); step();

    // Random traffic.
    repeat (3000) begin
      rand_stim();
      step();
    end
    set_idle(); step();

    repeat (10) begin
      if (exp_q.size() > 0) @(negedge clock);
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
